pbit_sweep_sampler: RTL and testbench
=====================================

Name: pbit_sweep_sampler

Overview:
- Consumes the one-hot p-bit update vector from the update sequencer and the p-bit state vector from the p-bit array.
- Detects sweep boundaries and discards a fixed burn-in.
- Over a programmable number of sweeps, accumulates per-p-bit ones counts and a count of sweeps whose state matches a target pattern. Firmware or the testbench uses these to estimate adder output probabilities.
- Sits directly downstream of the update sequencer, in parallel with the p-bit array.

Parameters:
- N_PBITS, 5, number of p-bits; width of update_in, pbit_state and target.
- COUNT_W, 16, width of n_samples and every counter.
- BURN_IN, 4, number of post-alignment sweep boundaries discarded before sampling. 0 is legal.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- update_in  in  N_PBITS  one-hot update vector from the sequencer. Only bit 0 is used.
- pbit_state  in  N_PBITS  current p-bit outputs.
- start  in  1  single-cycle run request.
- n_samples  in  COUNT_W  sweeps to accumulate. Latched on an accepted start.
- target  in  N_PBITS  match pattern. Latched on an accepted start.
- busy  out  1  high in ALIGN, BURN and SAMPLE.
- done  out  1  one-cycle pulse at end of run.
- ones_count  out  N_PBITS*COUNT_W  flattened; slice i = ones count for p-bit i.
- match_count  out  COUNT_W  sweeps with pbit_state == target.
- sample_count  out  COUNT_W  sweeps accumulated so far.

Behaviour:
- Reset: state = IDLE. busy, done, ones_count, match_count, sample_count, burn counter and latched regs all 0. Reset overrides everything, including mid-run; no done pulse is produced.
- Boundary: a cycle with update_in[0] == 1. The pbit_state in that cycle is the result of the just-completed sweep.
- States: IDLE, ALIGN, BURN, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - start = 1 latches n_samples and target and clears all counters.
  - Next state is ALIGN, or DONE if n_samples == 0.
  - start is ignored in every other state.
- ALIGN:
  - The first boundary is not sampled because the preceding sweep may be partial.
  - On that boundary go to BURN if BURN_IN > 0, else SAMPLE.
- BURN:
  - Each boundary increments burn_cnt.
  - The boundary that makes burn_cnt == BURN_IN moves the FSM to SAMPLE. That boundary is not sampled.
- SAMPLE, on each boundary:
  - ones slice i += pbit_state[i].
  - match_count += (pbit_state == target).
  - sample_count += 1.
  - If the new sample_count == latched n_samples, go to DONE.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - Next state is IDLE.
- Latency: done is high in the cycle immediately after the final sampled boundary.
- Counts stay stable from DONE until the next accepted start. Each counter is ≤ n_samples, so no overflow or saturation logic is needed.
- Non-boundary cycles: no counter changes. Changes in update_in bits 1..N_PBITS-1 and in pbit_state have no effect.
- Boundary in the same cycle as start: not counted; the FSM is still in IDLE.
- Total run length is (1 + BURN_IN + n_samples) boundaries, plus 1 cycle for DONE.

Decomposition:
- Shared package pbit_pkg holds:
  - the sampler state enum (IDLE/ALIGN/BURN/SAMPLE/DONE);
  - default N_PBITS and COUNT_W constants, shared with the update sequencer and the p-bit array.
- Sub-module pbit_ones_counter:
  - a COUNT_W counter with clr, en (boundary and SAMPLE) and bit inputs;
  - instantiated N_PBITS times via generate.
- The FSM, burn counter, match counter and sample counter stay in the top module.

Test Plan:
Common setup: N_PBITS=5, COUNT_W=8, BURN_IN=2, sequencer driving update_in; boundary every 5 cycles.
- Constant state: pbit_state=5'b10110, target=5'b10110, n_samples=10.
  - Required: ones slices [0..4] = 0,10,10,0,10; match_count=10; sample_count=10.
  - done pulses once, the cycle after the 13th boundary following start; busy is low again at that point.
- Alternating state: pbit_state toggles 5'b00000/5'b11111 on each boundary, target=5'b11111, n_samples=8.
  - Required: every ones slice = 4; match_count = 4.
- Zero samples: n_samples=0.
  - Required: done=1 the cycle after start; all counts 0; busy never asserted.
- Ignored starts: pulse start during BURN, and again during SAMPLE with n_samples=3.
  - Required: original n_samples kept; a single done pulse; counts equal those of an undisturbed run.
- Reset mid-run: assert reset mid-SAMPLE after 4 samples.
  - Required: all outputs 0 the next cycle; no done pulse.
  - A following start runs normally from zero.
- Back-to-back runs: second start issued after done.
  - Required: counters cleared at the accepted start.
  - Second result is independent of the first (e.g. first run all-ones, second run all-zeros gives ones slices = 0).

Source files
------------

// File: rtl/pbit_pkg.sv
// ----------------------------------------------------------------------------
// pbit_pkg
// Shared definitions for the p-bit datapath: the sweep sampler state
// encoding and the default array/counter sizes also used by the update
// sequencer and the p-bit array.
// ----------------------------------------------------------------------------
package pbit_pkg;

    localparam int unsigned PBIT_N_PBITS = 5;
    localparam int unsigned PBIT_COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_BURN   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } sampler_state_t;

endpackage

// File: rtl/pbit_ones_counter.sv
// ----------------------------------------------------------------------------
// pbit_ones_counter
// Per-p-bit ones counter. Clears on i_clr, and on an enabled cycle adds
// the sampled p-bit value.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high
//   i_clr    clear the count (accepted run start)
//   i_en     sampling boundary while sampling
//   i_bit    current p-bit value
//   o_count  registered ones count
// ----------------------------------------------------------------------------
module pbit_ones_counter
    import pbit_pkg::*;
#(
    parameter int unsigned COUNT_W = PBIT_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_bit,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && i_bit) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pbit_sweep_sampler.sv
// ----------------------------------------------------------------------------
// pbit_sweep_sampler
// Watches the sequencer's one-hot update vector for sweep boundaries
// (update_in[0]), skips the first (possibly partial) sweep and BURN_IN
// burn-in sweeps, then accumulates per-p-bit ones counts and target
// matches over n_samples sweeps.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   update_in     one-hot update vector; only bit 0 (sweep boundary) used
//   pbit_state    p-bit outputs; valid result of a sweep on a boundary
//   start         single-cycle run request, accepted only in IDLE
//   n_samples     sweeps to accumulate, latched on accepted start
//   target        match pattern, latched on accepted start
//   busy          high in ALIGN, BURN and SAMPLE
//   done          one-cycle pulse at end of run
//   ones_count    flattened, slice i = ones count of p-bit i
//   match_count   sampled sweeps with pbit_state == target
//   sample_count  sweeps accumulated so far
// ----------------------------------------------------------------------------
module pbit_sweep_sampler
    import pbit_pkg::*;
#(
    parameter int unsigned N_PBITS = PBIT_N_PBITS,
    parameter int unsigned COUNT_W = PBIT_COUNT_W,
    parameter int unsigned BURN_IN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PBITS-1:0]         update_in,
    input  logic [N_PBITS-1:0]         pbit_state,
    input  logic                       start,
    input  logic [COUNT_W-1:0]         n_samples,
    input  logic [N_PBITS-1:0]         target,
    output logic                       busy,
    output logic                       done,
    output logic [N_PBITS*COUNT_W-1:0] ones_count,
    output logic [COUNT_W-1:0]         match_count,
    output logic [COUNT_W-1:0]         sample_count
);

    // At least one bit so BURN_IN of 0 or 1 still gives a legal vector.
    localparam int unsigned BURN_W = (BURN_IN > 1) ? $clog2(BURN_IN + 1) : 1;

    sampler_state_t       r_state;
    logic [COUNT_W-1:0]   r_n_samples;
    logic [N_PBITS-1:0]   r_target;
    logic [BURN_W-1:0]    r_burn_cnt;
    logic [COUNT_W-1:0]   r_match_count;
    logic [COUNT_W-1:0]   r_sample_count;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_boundary;
    logic                 w_start_acc;
    logic                 w_sample_en;
    logic                 w_match;
    logic [BURN_W-1:0]    w_burn_next;
    logic [COUNT_W-1:0]   w_sample_next;
    logic                 w_unused_upd;

    assign w_boundary    = update_in[0];
    assign w_start_acc   = start && (r_state == ST_IDLE);
    assign w_sample_en   = w_boundary && (r_state == ST_SAMPLE);
    assign w_match       = (pbit_state == r_target);
    assign w_burn_next   = r_burn_cnt + BURN_W'(1);
    assign w_sample_next = r_sample_count + COUNT_W'(1);
    // Only the sweep-boundary bit matters; the rest are deliberately ignored.
    assign w_unused_upd  = ^update_in[N_PBITS-1:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_n_samples    <= '0;
            r_target       <= '0;
            r_burn_cnt     <= '0;
            r_match_count  <= '0;
            r_sample_count <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n_samples    <= n_samples;
                        r_target       <= target;
                        r_burn_cnt     <= '0;
                        r_match_count  <= '0;
                        r_sample_count <= '0;
                        if (n_samples == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_ALIGN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ALIGN: begin
                    // First boundary closes a possibly partial sweep: skip it.
                    if (w_boundary) begin
                        r_state <= (BURN_IN > 0) ? ST_BURN : ST_SAMPLE;
                    end
                end
                ST_BURN: begin
                    if (w_boundary) begin
                        r_burn_cnt <= w_burn_next;
                        if (w_burn_next == BURN_W'(BURN_IN)) begin
                            r_state <= ST_SAMPLE;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (w_boundary) begin
                        r_match_count  <= r_match_count + COUNT_W'(w_match);
                        r_sample_count <= w_sample_next;
                        // done/busy are registered here so the pulse lands
                        // in the DONE cycle right after the last sample.
                        if (w_sample_next == r_n_samples) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_PBITS; g++) begin : g_ones
        pbit_ones_counter #(
            .COUNT_W (COUNT_W)
        ) u_ones (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (w_start_acc),
            .i_en    (w_sample_en),
            .i_bit   (pbit_state[g]),
            .o_count (ones_count[g*COUNT_W +: COUNT_W])
        );
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign match_count  = r_match_count;
    assign sample_count = r_sample_count;

endmodule

// File: tb/tb_pbit_sweep_sampler.sv
// ----------------------------------------------------------------------------
// tb_pbit_sweep_sampler
// Directed bench for pbit_sweep_sampler (N_PBITS=5, COUNT_W=8, BURN_IN=2).
// A rotating one-hot update vector models the sequencer, giving a sweep
// boundary every 5 cycles.
// ----------------------------------------------------------------------------
module tb_pbit_sweep_sampler;

    localparam int unsigned NP = 5;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   update_in;
    logic [NP-1:0]   pbit_state;
    logic            start;
    logic [CW-1:0]   n_samples;
    logic [NP-1:0]   target;
    logic            busy;
    logic            done;
    logic [NP*CW-1:0] ones_count;
    logic [CW-1:0]   match_count;
    logic [CW-1:0]   sample_count;

    int  n_checks = 0;
    int  n_fails  = 0;
    int  phase    = 0;
    int  bnd      = 0;
    bit  last_bnd = 1'b0;
    bit  alt_mode = 1'b0;

    always #5 clk = ~clk;

    pbit_sweep_sampler #(
        .N_PBITS (NP),
        .COUNT_W (CW),
        .BURN_IN (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .update_in    (update_in),
        .pbit_state   (pbit_state),
        .start        (start),
        .n_samples    (n_samples),
        .target       (target),
        .busy         (busy),
        .done         (done),
        .ones_count   (ones_count),
        .match_count  (match_count),
        .sample_count (sample_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance the sequencer model and note whether the edge
    // just taken was a sweep boundary.
    task automatic cycle();
        last_bnd = update_in[0];
        @(posedge clk);
        #1;
        if (last_bnd) begin
            bnd++;
            if (alt_mode) pbit_state = ~pbit_state;
        end
        phase     = (phase + 1) % 5;
        update_in = NP'(1) << phase;
    endtask

    task automatic check_counts(input string tag, input logic [NP*CW-1:0] exp_ones,
                                input int exp_match, input int exp_samp);
        for (int i = 0; i < NP; i++) begin
            check_eq($sformatf("%s ones[%0d]", tag, i), 64'(ones_count[i*CW +: CW]),
                     64'(exp_ones[i*CW +: CW]));
        end
        check_eq({tag, " match_count"}, 64'(match_count), 64'(exp_match));
        check_eq({tag, " sample_count"}, 64'(sample_count), 64'(exp_samp));
    endtask

    // Issue a start, then watch for the done pulse (bounded) and check its
    // timing in boundaries since start. Optionally fire spurious starts in
    // BURN (after boundary 2) and SAMPLE (after boundary 5).
    task automatic run(input string tag, input logic [CW-1:0] n, input logic [NP-1:0] tgt,
                       input bit disturb, input int exp_total);
        int  pulses       = 0;
        int  extra        = 0;
        int  done_bnd     = -1;
        bit  busy_ever    = 1'b0;
        bit  busy_at_done = 1'b1;
        bit  timing_ok    = 1'b0;
        n_samples = n;
        target    = tgt;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        bnd   = 0;
        for (int c = 0; c < 400 && extra < 3; c++) begin
            if (busy) busy_ever = 1'b1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    done_bnd     = bnd;
                    busy_at_done = busy;
                    timing_ok    = (n == 0) ? (c == 0) : last_bnd;
                end
            end else if (pulses > 0) begin
                extra++;
            end
            if (disturb && (bnd == 2 || bnd == 5) && phase == 2) begin
                start     = 1'b1;
                n_samples = 8'd3;
                target    = 5'b00000;
            end else begin
                start = 1'b0;
            end
            if (extra < 3) cycle();
        end
        start = 1'b0;
        check_eq({tag, " done pulses"}, 64'(pulses), 64'd1);
        check_eq({tag, " done boundary"}, 64'(done_bnd), 64'(exp_total));
        check_eq({tag, " done timing"}, 64'(timing_ok), 64'd1);
        check_eq({tag, " busy at done"}, 64'(busy_at_done), 64'd0);
        check_eq({tag, " busy seen"}, 64'(busy_ever), (n != 0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        int dones_after_reset;
        reset      = 1'b1;
        update_in  = 5'b00001;
        pbit_state = 5'b00000;
        start      = 1'b0;
        n_samples  = '0;
        target     = '0;
        repeat (3) cycle();
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
        check_counts("reset", '0, 0, 0);
        reset = 1'b0;
        cycle();

        // Constant state: 1 align + 2 burn + 10 samples = 13 boundaries.
        pbit_state = 5'b10110;
        run("const", 8'd10, 5'b10110, 1'b0, 13);
        check_counts("const", {8'd10, 8'd0, 8'd10, 8'd10, 8'd0}, 10, 10);

        // Alternating 00000/11111 across 8 sampled sweeps.
        pbit_state = 5'b00000;
        alt_mode   = 1'b1;
        run("alt", 8'd8, 5'b11111, 1'b0, 11);
        alt_mode   = 1'b0;
        check_counts("alt", {5{8'd4}}, 4, 8);

        // Zero samples: done straight after start, previous counts cleared.
        pbit_state = 5'b11111;
        run("zero", 8'd0, 5'b11111, 1'b0, 0);
        check_counts("zero", '0, 0, 0);

        // Spurious starts in BURN and SAMPLE must be ignored.
        pbit_state = 5'b10110;
        run("ignore", 8'd6, 5'b10110, 1'b1, 9);
        check_counts("ignore", {8'd6, 8'd0, 8'd6, 8'd6, 8'd0}, 6, 6);

        // Reset after 4 samples of a 10-sample run.
        pbit_state = 5'b10110;
        n_samples  = 8'd10;
        target     = 5'b10110;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        bnd   = 0;
        for (int c = 0; c < 200 && bnd < 7; c++) cycle();
        check_eq("midrun sample_count", 64'(sample_count), 64'd4);
        check_eq("midrun busy", 64'(busy), 64'd1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        check_counts("rst", '0, 0, 0);
        dones_after_reset = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) dones_after_reset++;
            cycle();
        end
        check_eq("rst no done", 64'(dones_after_reset), 64'd0);
        run("post-rst", 8'd5, 5'b01001, 1'b0, 8);
        check_counts("post-rst", {8'd5, 8'd0, 8'd5, 8'd5, 8'd0}, 0, 5);

        // Back-to-back: all-ones run then all-zeros run.
        pbit_state = 5'b11111;
        run("b2b1", 8'd4, 5'b11111, 1'b0, 7);
        check_counts("b2b1", {5{8'd4}}, 4, 4);
        pbit_state = 5'b00000;
        run("b2b2", 8'd3, 5'b11111, 1'b0, 6);
        check_counts("b2b2", '0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
